system1_pio_in_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO slave: the next generation of the system1 input port.

---
 rtl/system1_pio_pkg.sv | 17 +
 rtl/system1_pio_sync.sv | 26 ++
 rtl/system1_pio_in_irq.sv | 104 ++++++++++
 tb/tb_system1_pio_in_irq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/system1_pio_pkg.sv
// system1 PIO shared definitions.
// Register map and parameter encodings for the input PIO family.
package system1_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/system1_pio_sync.sv
// Multi-stage input synchroniser for system1 PIO variants.
// Stage 0 samples d; q is the oldest stage.
module system1_pio_sync #(
  parameter int WIDTH       = 32,
  parameter int STAGES      = 2,
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {(STAGES*WIDTH){RESET_VALUE}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/system1_pio_in_irq.sv
// Avalon-MM input PIO with per-bit edge capture and maskable irq.
// Reads are registered and not gated by chipselect.
module system1_pio_in_irq #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_TYPE    = 1,
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  import system1_pio_pkg::*;

  logic [DATA_WIDTH-1:0] data_s;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] edgecap;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [31:0]           rd_mux;
  logic                  wr_en;
  logic                  wr_mask;
  logic                  wr_edge;
  logic                  irq_src;

  system1_pio_sync #(
    .WIDTH      (DATA_WIDTH),
    .STAGES     (SYNC_STAGES),
    .RESET_VALUE(RESET_VALUE)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (in_port),
    .q      (data_s)
  );

  // prev shares the chain's reset value so release sees no edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= {DATA_WIDTH{RESET_VALUE}};
    else          prev <= data_s;
  end

  always_comb begin
    rise     = data_s & ~prev;
    fall     = ~data_s & prev;
    edge_det = rise | fall;
    if (EDGE_TYPE == EDGE_RISE)      edge_det = rise;
    else if (EDGE_TYPE == EDGE_FALL) edge_det = fall;
  end

  assign wr_en   = chipselect & ~write_n;
  assign wr_mask = wr_en & (address == PIO_ADDR_MASK);
  assign wr_edge = wr_en & (address == PIO_ADDR_EDGE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     irqmask <= '0;
    else if (wr_mask) irqmask <= writedata[DATA_WIDTH-1:0];
  end

  // new edges are OR-ed in after the clear so a same-cycle edge survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
    end else if (wr_edge) begin
      edgecap <= (edgecap & ~writedata[DATA_WIDTH-1:0]) | edge_det;
    end else begin
      edgecap <= edgecap | edge_det;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      PIO_ADDR_DATA: rd_mux[DATA_WIDTH-1:0] = data_s;
      PIO_ADDR_MASK: rd_mux[DATA_WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGE: rd_mux[DATA_WIDTH-1:0] = edgecap;
      default:       rd_mux = '0;
    endcase
  end

  assign irq_src = (IRQ_TYPE == IRQ_EDGE) ? |(edgecap & irqmask)
                                          : |(data_s & irqmask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= irq_src;
    end
  end

endmodule

// File: tb/tb_system1_pio_in_irq.sv
// Scoreboard bench: three parameter sets share one stimulus stream.
// A sample-history model predicts readdata/irq after every clk.
module tb_system1_pio_in_irq;

  localparam int N = 3;
  localparam int P_DW [N] = '{8, 32, 16};
  localparam int P_ST [N] = '{2, 3, 4};
  localparam int P_ET [N] = '{2, 0, 1};
  localparam int P_IT [N] = '{1, 0, 1};
  localparam int P_RV [N] = '{0, 1, 0};

  typedef struct packed {
    logic [N-1:0]       irq;
    logic [N-1:0][31:0] rd;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       in_bus = '0;
  logic [N-1:0][31:0] rd_o;
  logic [N-1:0]      irq_o;

  exp_t        sbq[$];
  logic [31:0] smp [N][0:4];
  logic [31:0] ec [N];
  logic [31:0] mk [N];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n = 0;

  always #5 clk = ~clk;

  system1_pio_in_irq #(
    .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2),
    .IRQ_TYPE(1), .RESET_VALUE(1'b0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_bus[7:0]),
    .readdata(rd_o[0]), .irq(irq_o[0])
  );

  system1_pio_in_irq #(
    .DATA_WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(0),
    .IRQ_TYPE(0), .RESET_VALUE(1'b1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_bus),
    .readdata(rd_o[1]), .irq(irq_o[1])
  );

  system1_pio_in_irq #(
    .DATA_WIDTH(16), .SYNC_STAGES(4), .EDGE_TYPE(1),
    .IRQ_TYPE(1), .RESET_VALUE(1'b0)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_bus[15:0]),
    .readdata(rd_o[2]), .irq(irq_o[2])
  );

  function automatic logic [31:0] wmask(int dw);
    if (dw >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << dw) - 32'h1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 5; j++)
        smp[i][j] = (P_RV[i] != 0) ? wmask(P_DW[i]) : 32'h0;
      ec[i] = '0;
      mk[i] = '0;
    end
  endtask

  // smp[i][j] = in_port sampled j+1 edges ago; data_s lags by SYNC_STAGES
  task automatic model_step(input logic [1:0] a, input logic cs,
                            input logic wn, input logic [31:0] wd,
                            input logic [31:0] inp, output exp_t e);
    logic [31:0] m, ds, pv, ed;
    logic        wr;
    e = '0;
    wr = cs && !wn;
    for (int i = 0; i < N; i++) begin
      m  = wmask(P_DW[i]);
      ds = smp[i][P_ST[i]-1];
      pv = smp[i][P_ST[i]];
      case (P_ET[i])
        0:       ed = ds & ~pv;
        1:       ed = ~ds & pv;
        default: ed = ds ^ pv;
      endcase
      case (a)
        2'd0:    e.rd[i] = ds;
        2'd2:    e.rd[i] = mk[i];
        2'd3:    e.rd[i] = ec[i];
        default: e.rd[i] = 32'h0;
      endcase
      e.irq[i] = (P_IT[i] == 1) ? |(ec[i] & mk[i]) : |(ds & mk[i]);
      if (wr && a == 2'd3) ec[i] = (ec[i] & ~(wd & m)) | ed;
      else                 ec[i] = ec[i] | ed;
      if (wr && a == 2'd2) mk[i] = wd & m;
      for (int j = 4; j > 0; j--) smp[i][j] = smp[i][j-1];
      smp[i][0] = inp & m;
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic cs,
                       input logic wn, input logic [31:0] wd,
                       input logic [31:0] inp);
    exp_t e;
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    in_bus     = inp;
    model_step(a, cs, wn, wd, inp, e);
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic [1:0] a, input logic cs,
                     input logic wn, input logic [31:0] wd,
                     input logic [31:0] inp);
    @(negedge clk);
    drive(a, cs, wn, wd, inp);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rd_o[i] !== 32'h0 || irq_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s dut%0d: readdata=%h irq=%b, need 0/0",
                 tag, i, rd_o[i], irq_o[i]);
      end
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cyc_n++;
      for (int i = 0; i < N; i++) begin
        checks++;
        if (rd_o[i] !== e.rd[i]) begin
          errors++;
          $display("FAIL readdata dut%0d cyc %0d: got %h, expected %h",
                   i, cyc_n, rd_o[i], e.rd[i]);
        end
        checks++;
        if (irq_o[i] !== e.irq[i]) begin
          errors++;
          $display("FAIL irq dut%0d cyc %0d: got %b, expected %b",
                   i, cyc_n, irq_o[i], e.irq[i]);
        end
      end
    end
  end

  initial begin
    logic [31:0] inp;
    logic [1:0]  a;
    logic        cs, wn;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    @(negedge clk);
    reset_n = 1'b1;
    drive(2'd0, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) cyc(2'(k), 1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) cyc(2'(k), 1'b1, 1'b1, 32'h0, 32'h0);

    // hold a pattern and read data
    for (int k = 0; k < 8; k++) cyc(2'd0, 1'b1, 1'b1, 32'h0, 32'h0000_00A5);
    cyc(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    for (int k = 0; k < 6; k++) cyc(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);

    // mask bit0, raise bit0, clear with W1C
    cyc(2'd2, 1'b1, 1'b0, 32'h0000_0001, 32'h0);
    for (int k = 0; k < 7; k++) cyc(2'd3, 1'b1, 1'b1, 32'h0, 32'h1);
    cyc(2'd3, 1'b1, 1'b0, 32'h0000_0001, 32'h1);
    for (int k = 0; k < 3; k++) cyc(2'd3, 1'b1, 1'b1, 32'h0, 32'h1);

    // clear every cycle while bit0 keeps toggling
    for (int k = 0; k < 16; k++)
      cyc(2'd3, 1'b1, 1'b0, 32'h1, (k % 2 == 0) ? 32'h0 : 32'h1);

    // level irq on bit3, then mask drop
    cyc(2'd2, 1'b1, 1'b0, 32'h0000_0008, 32'h8);
    for (int k = 0; k < 6; k++) cyc(2'd0, 1'b1, 1'b1, 32'h0, 32'h8);
    for (int k = 0; k < 6; k++) cyc(2'd0, 1'b1, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 6; k++) cyc(2'd0, 1'b1, 1'b1, 32'h0, 32'h8);
    cyc(2'd2, 1'b1, 1'b0, 32'h0, 32'h8);
    for (int k = 0; k < 3; k++) cyc(2'd2, 1'b1, 1'b1, 32'h0, 32'h8);

    // top bit of the 8-bit bank up then down
    cyc(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    for (int k = 0; k < 3; k++) cyc(2'd3, 1'b1, 1'b1, 32'h0, 32'h80);
    for (int k = 0; k < 8; k++) cyc(2'd3, 1'b1, 1'b1, 32'h0, 32'h0);

    inp = 32'h0;
    for (int k = 0; k < 3000; k++) begin
      a  = 2'($urandom_range(0, 3));
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) inp = $urandom;
        else inp = inp ^ (32'h1 << $urandom_range(0, 31));
      end
      cyc(a, cs, wn, $urandom, inp);
    end

    // arm everything, then reset mid-operation
    cyc(2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    for (int k = 0; k < 8; k++) cyc(2'd2, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    drive(2'd2, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
    for (int k = 0; k < 10; k++) cyc(2'(k % 4), 1'b1, 1'b1, 32'h0, 32'h0);

    @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
